// File: rtl/hit_judge.sv
// Whack-a-mole hit judge: arms on a nonzero mole pattern, classifies switch toggles or a timeout.
// Optional macro HIT_STREAK_BONUS_EN: hits scored 2 instead of 1 once the streak reaches BONUS_AT.
module hit_judge #(
  parameter int N_HOLES  = 5,
  parameter int SCORE_W  = 8,
  parameter int WINDOW   = 16,
  parameter int BONUS_AT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               mole_valid,
  input  logic [N_HOLES-1:0] mole_in,
  input  logic [N_HOLES-1:0] switch_in,
  output logic               hit,
  output logic               miss,
  output logic               armed,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] streak
);

  typedef enum logic [0:0] {IDLE = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [7:0]         WINDOW_L = 8'(WINDOW);
  localparam logic [SCORE_W-1:0] SAT      = {SCORE_W{1'b1}};

  state_t             state_q, state_d;
  logic [N_HOLES-1:0] switch_q;
  logic [N_HOLES-1:0] target_q, target_d;
  logic [7:0]         timer_q, timer_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] streak_q, streak_d;
  logic [N_HOLES-1:0] toggle_s;
  logic               good_s;
  logic [1:0]         inc_s;
  logic [SCORE_W:0]   score_sum_s;

  assign toggle_s = switch_in ^ switch_q;
  // A whack is good only if it touches a target hole and nothing outside the target.
  assign good_s   = (|(toggle_s & target_q)) && !(|(toggle_s & ~target_q));

`ifdef HIT_STREAK_BONUS_EN
  assign inc_s = (streak_q >= SCORE_W'(BONUS_AT)) ? 2'd2 : 2'd1;
`else
  assign inc_s = 2'd1;
`endif

  assign score_sum_s = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, inc_s};

  // Next-state, judgement and scoring.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    timer_d  = timer_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    score_d  = score_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: begin
        if (mole_valid && (|mole_in)) begin
          state_d  = ARMED;
          target_d = mole_in;
          timer_d  = WINDOW_L;
        end else begin
          state_d  = IDLE;
        end
      end
      ARMED: begin
        // A toggle wins over a timeout landing in the same cycle.
        if (|toggle_s) begin
          hit_d   = good_s;
          miss_d  = !good_s;
          state_d = IDLE;
          timer_d = 8'd0;
        end else if (tick) begin
          if (timer_q == 8'd1) begin
            miss_d  = 1'b1;
            state_d = IDLE;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end else begin
          timer_d = timer_q;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 8'd0;
      end
    endcase

    if (hit_d) begin
      score_d  = score_sum_s[SCORE_W] ? SAT : score_sum_s[SCORE_W-1:0];
      streak_d = (streak_q == SAT) ? SAT : streak_q + {{(SCORE_W-1){1'b0}}, 1'b1};
    end else if (miss_d) begin
      streak_d = {SCORE_W{1'b0}};
    end else begin
      streak_d = streak_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    switch_q <= switch_in;
    if (reset) begin
      state_q  <= IDLE;
      target_q <= {N_HOLES{1'b0}};
      timer_q  <= 8'd0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= {SCORE_W{1'b0}};
      streak_q <= {SCORE_W{1'b0}};
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      streak_q <= streak_d;
    end
  end

  assign hit    = hit_q;
  assign miss   = miss_q;
  assign armed  = (state_q == ARMED);
  assign score  = score_q;
  assign streak = streak_q;

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: event-level reference model compared every cycle, plus directed literal checks.
module tb_hit_judge;
  localparam int N = 5;
  localparam int SW = 8;
  localparam int WIN = 4;
  localparam int BON = 3;
  localparam int SMAX = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tick = 1'b0;
  logic         mole_valid = 1'b0;
  logic [N-1:0] mole_in = '0;
  logic [N-1:0] switch_in = '0;
  logic         hit, miss, armed;
  logic [SW-1:0] score, streak;

  int tests = 0;
  int fails = 0;

  hit_judge #(.N_HOLES(N), .SCORE_W(SW), .WINDOW(WIN), .BONUS_AT(BON)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mole_valid(mole_valid),
    .mole_in(mole_in), .switch_in(switch_in), .hit(hit), .miss(miss),
    .armed(armed), .score(score), .streak(streak)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the game as events, not as a state machine.
  bit m_valid = 0, m_armed = 0, m_hit = 0, m_miss = 0;
  bit [N-1:0] m_target = '0, m_prev = '0;
  int m_left = 0, m_score = 0, m_streak = 0;

  initial begin
    forever begin
      bit was, h, ms;
      bit [N-1:0] tog;
      int inc;
      @(posedge clk);
      if (reset) begin
        m_armed = 0; m_hit = 0; m_miss = 0; m_score = 0; m_streak = 0;
        m_prev = switch_in; m_valid = 1;
      end else begin
        was = m_armed; tog = switch_in ^ m_prev; h = 0; ms = 0;
        if (was) begin
          if (tog != 0) begin
            if ((tog & ~m_target) == 0) h = 1; else ms = 1;
          end else if (tick) begin
            m_left = m_left - 1;
            if (m_left == 0) ms = 1;
          end
        end
        if (h) begin
          inc = 1;
`ifdef HIT_STREAK_BONUS_EN
          if (m_streak >= BON) inc = 2;
`endif
          m_score = (m_score + inc > SMAX) ? SMAX : m_score + inc;
          m_streak = (m_streak + 1 > SMAX) ? SMAX : m_streak + 1;
          m_armed = 0;
        end else if (ms) begin
          m_streak = 0;
          m_armed = 0;
        end else if (!was && mole_valid && mole_in != 0) begin
          m_armed = 1; m_target = mole_in; m_left = WIN;
        end
        m_hit = h; m_miss = ms; m_prev = switch_in;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("model_hit", int'(hit), int'(m_hit));
        check("model_miss", int'(miss), int'(m_miss));
        check("model_armed", int'(armed), int'(m_armed));
        check("model_score", int'(score), m_score);
        check("model_streak", int'(streak), m_streak);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Strobe a mole and whack exactly its holes; returns with the hit pulse showing.
  task automatic whack(input logic [N-1:0] t);
    mole_valid = 1'b1; mole_in = t;
    step();
    mole_valid = 1'b0; mole_in = '0;
    switch_in = switch_in ^ t;
    step();
  endtask

  int exp_five [5];

  initial begin
`ifdef HIT_STREAK_BONUS_EN
    exp_five = '{1, 2, 3, 5, 7};
`else
    exp_five = '{1, 2, 3, 4, 5};
`endif
    step(); step();
    reset = 1'b0;
    check("rst_score", int'(score), 0);
    check("rst_armed", int'(armed), 0);
    check("rst_hitmiss", int'(hit) + int'(miss), 0);

    // Single correct whack.
    mole_valid = 1'b1; mole_in = 5'b00100;
    step();
    mole_valid = 1'b0; mole_in = '0;
    check("arm_rise", int'(armed), 1);
    switch_in = 5'b00100;
    check("no_hit_yet", int'(hit), 0);
    step();
    check("hit_pulse", int'(hit), 1);
    check("hit_score", int'(score), 1);
    check("hit_streak", int'(streak), 1);
    check("hit_armed_fall", int'(armed), 0);
    step();
    check("hit_one_cycle", int'(hit), 0);

    // Wrong switch.
    switch_in = 5'b00000;
    step();
    check("idle_toggle_ignored", int'(armed) + int'(miss), 0);
    mole_valid = 1'b1; mole_in = 5'b00100;
    step();
    mole_valid = 1'b0; mole_in = '0;
    switch_in = 5'b01000;
    step();
    check("wrong_miss", int'(miss), 1);
    check("wrong_nohit", int'(hit), 0);
    check("wrong_score", int'(score), 1);
    check("wrong_streak", int'(streak), 0);

    // Timeout after WINDOW ticks.
    mole_valid = 1'b1; mole_in = 5'b10000;
    step();
    mole_valid = 1'b0; mole_in = '0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("tmo_not_yet", int'(miss), 0);
    check("tmo_still_armed", int'(armed), 1);
    step();
    tick = 1'b0;
    check("tmo_miss", int'(miss), 1);
    check("tmo_armed_fall", int'(armed), 0);

    // Toggle on the 4th tick wins.
    mole_valid = 1'b1; mole_in = 5'b10000;
    step();
    mole_valid = 1'b0; mole_in = '0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) step();
    switch_in = switch_in ^ 5'b10000;
    step();
    tick = 1'b0;
    check("prio_hit", int'(hit), 1);
    check("prio_nomiss", int'(miss), 0);
    check("prio_score", int'(score), 2);

    // Reset while armed abandons the mole.
    mole_valid = 1'b1; mole_in = 5'b00010;
    step();
    mole_valid = 1'b0; mole_in = '0;
    reset = 1'b1;
    switch_in = switch_in ^ 5'b00010;
    step();
    reset = 1'b0;
    check("rstarm_hitmiss", int'(hit) + int'(miss), 0);
    check("rstarm_armed", int'(armed), 0);
    check("rstarm_score", int'(score), 0);
    check("rstarm_streak", int'(streak), 0);
    mole_valid = 1'b1; mole_in = 5'b00000;
    step();
    mole_valid = 1'b0;
    step();
    check("zero_mole_ignored", int'(armed), 0);

    // Five back-to-back hits.
    for (int i = 0; i < 5; i++) begin
      whack(5'b00001);
      check("five_score", int'(score), exp_five[i]);
    end
    check("five_streak", int'(streak), 5);

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 2) == 0);
      mole_valid = ($urandom_range(0, 3) == 0);
      mole_in = N'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0)
          switch_in = switch_in ^ m_target;
        else
          switch_in = switch_in ^ N'($urandom_range(1, 31));
      end
      step();
    end
    reset = 1'b0; tick = 1'b0; mole_valid = 1'b0; mole_in = '0;

    // Saturation.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 260; i++) whack(5'b01010);
    check("sat_score", int'(score), 255);
    check("sat_streak", int'(streak), 255);
    whack(5'b00001);
    check("sat_no_wrap", int'(score), 255);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
